// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (see arb_pick).
package mem_arb_pkg;

    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef logic port_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester + memory bundle: slave is the arbiter, master drives requests and mem_rd.
// Latency: n/a (wiring only). Backpressure: requesters hold req until rvalid.
// No configuration macros.
interface mem_arb_if #(
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r1_req;
    logic              r0_we;
    logic              r1_we;
    logic [DATA_W-1:0] r0_adr;
    logic [DATA_W-1:0] r1_adr;
    logic [DATA_W-1:0] r0_wdata;
    logic [DATA_W-1:0] r1_wdata;
    logic              r0_gnt;
    logic              r1_gnt;
    logic              r0_rvalid;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r0_rdata;
    logic [DATA_W-1:0] r1_rdata;
    logic [DATA_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;
    logic              busy;

    modport slave (
        input  r0_req, r1_req, r0_we, r1_we, r0_adr, r1_adr, r0_wdata, r1_wdata, mem_rd,
        output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
               mem_adr, mem_wd, mem_we, busy
    );

    modport master (
        output r0_req, r1_req, r0_we, r1_we, r0_adr, r1_adr, r0_wdata, r1_wdata, mem_rd,
        input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
               mem_adr, mem_wd, mem_we, busy
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between two requesters; only place ARB_ROUND_ROBIN_EN matters.
// Latency: combinational. Backpressure: none, losing port simply keeps its req high.
// ARB_ROUND_ROBIN_EN: defined = alternate on contention, undefined = port 0 priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic     r0_req,
    input  logic     r1_req,
    input  port_id_t last,
    output port_id_t winner
);

    always_comb begin
        winner = last;
`ifdef ARB_ROUND_ROBIN_EN
        if (r0_req && r1_req) begin
            winner = ~last;
        end else if (r0_req) begin
            winner = 1'b0;
        end else if (r1_req) begin
            winner = 1'b1;
        end
`else
        if (r0_req) begin
            winner = 1'b0;
        end else if (r1_req) begin
            winner = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (MIPS core / program loader) in front of one single-port memory.
// Latency: rvalid in the cycle after edge k+WAIT_CYCLES for a request accepted at edge k.
// Backpressure: one transaction at a time; losers hold req. Policy macro: ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int DATA_W      = 32
) (
    input  logic     clk,
    input  logic     reset,
    mem_arb_if.slave bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_DONE   = DONE;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    port_id_t          winner_q;
    port_id_t          last_q;
    port_id_t          pick;
    logic              we_q;
    logic [DATA_W-1:0] adr_q;
    logic [DATA_W-1:0] wd_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              any_req;
    logic              in_access;
    logic              in_done;

    assign any_req = bus.r0_req | bus.r1_req;

    arb_pick u_pick (
        .r0_req (bus.r0_req),
        .r1_req (bus.r1_req),
        .last   (last_q),
        .winner (pick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wd_q     <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        winner_q <= pick;
                        last_q   <= pick;
                        we_q     <= pick ? bus.r1_we    : bus.r0_we;
                        adr_q    <= pick ? bus.r1_adr   : bus.r0_adr;
                        wd_q     <= pick ? bus.r1_wdata : bus.r0_wdata;
                        cnt      <= CNT_LOAD;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Memory data is valid once the counter has run out; writes leave rdata alone.
                    if (cnt == 4'd0) begin
                        if (!we_q) begin
                            if (winner_q) begin
                                rdata1_q <= bus.mem_rd;
                            end else begin
                                rdata0_q <= bus.mem_rd;
                            end
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state == S_ACCESS);
    assign in_done   = (state == S_DONE);

    // Outputs decode straight from state so an async reset clears them immediately.
    assign bus.mem_adr   = in_access ? adr_q : '0;
    assign bus.mem_wd    = in_access ? wd_q  : '0;
    assign bus.mem_we    = in_access && we_q && (cnt == CNT_LOAD);
    assign bus.r0_gnt    = (in_access || in_done) && !winner_q;
    assign bus.r1_gnt    = (in_access || in_done) &&  winner_q;
    assign bus.r0_rvalid = in_done && !winner_q;
    assign bus.r1_rvalid = in_done &&  winner_q;
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=1 instance.
// Expected contention order follows ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mem_arb_if #(.DATA_W(32)) bus  ();
    mem_arb_if #(.DATA_W(32)) bus2 ();

    mem_arbiter #(.WAIT_CYCLES(2), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_arbiter #(.WAIT_CYCLES(1), .DATA_W(32)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int   ngr;
        int   both;
        int   seen;
        int   gcyc [4];
        logic gwin [4];
        logic pb;
        logic exp_win;

        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.r0_req = 1'b1;  bus.r1_req = 1'b0;  bus.r0_we = 1'b0;  bus.r1_we = 1'b0;
        bus.r0_adr = 32'h40; bus.r1_adr = '0;   bus.r0_wdata = '0; bus.r1_wdata = '0;
        bus.mem_rd = 32'hFFFF_FFFF;
        bus2.r0_req = 1'b0; bus2.r1_req = 1'b0; bus2.r0_we = 1'b0; bus2.r1_we = 1'b0;
        bus2.r0_adr = '0;   bus2.r1_adr = '0;   bus2.r0_wdata = '0; bus2.r1_wdata = '0;
        bus2.mem_rd = '0;

        // Reset holds everything at zero even with a request pending
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   bus.busy,      0);
        chk("rst_gnt0",   bus.r0_gnt,    0);
        chk("rst_rvalid", bus.r0_rvalid, 0);
        chk("rst_rdata0", bus.r0_rdata,  0);
        chk("rst_madr",   bus.mem_adr,   0);
        chk("rst_mwe",    bus.mem_we,    0);
        bus.r0_req = 1'b0;
        reset = 1'b1;

        // r0 read of 0x40
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_adr = 32'h40;
        bus.mem_rd = 32'h1234_ABCD;
        #1;
        chk("rd_idle_busy", bus.busy,    0);
        chk("rd_idle_madr", bus.mem_adr, 0);
        tick();
        chk("rd_c1_gnt",    bus.r0_gnt,    1);
        chk("rd_c1_busy",   bus.busy,      1);
        chk("rd_c1_madr",   bus.mem_adr,   32'h40);
        chk("rd_c1_mwe",    bus.mem_we,    0);
        chk("rd_c1_rvalid", bus.r0_rvalid, 0);
        tick();
        chk("rd_c2_gnt",    bus.r0_gnt,    1);
        chk("rd_c2_madr",   bus.mem_adr,   32'h40);
        chk("rd_c2_rvalid", bus.r0_rvalid, 0);
        tick();
        chk("rd_c3_gnt",    bus.r0_gnt,    1);
        chk("rd_c3_gnt1",   bus.r1_gnt,    0);
        chk("rd_c3_rvalid", bus.r0_rvalid, 1);
        chk("rd_c3_rdata",  bus.r0_rdata,  32'h1234_ABCD);
        bus.r0_req = 1'b0;
        tick();
        chk("rd_c4_gnt",    bus.r0_gnt,    0);
        chk("rd_c4_rvalid", bus.r0_rvalid, 0);
        chk("rd_c4_busy",   bus.busy,      0);

        // r1 write of 0xDEADBEEF to 0x100; mem_rd must not leak into r1_rdata
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_adr = 32'h100; bus.r1_wdata = 32'hDEAD_BEEF;
        bus.mem_rd = 32'h5555_5555;
        tick();
        chk("wr_c1_mwe",  bus.mem_we,  1);
        chk("wr_c1_madr", bus.mem_adr, 32'h100);
        chk("wr_c1_mwd",  bus.mem_wd,  32'hDEAD_BEEF);
        chk("wr_c1_gnt1", bus.r1_gnt,  1);
        chk("wr_c1_gnt0", bus.r0_gnt,  0);
        tick();
        chk("wr_c2_mwe",  bus.mem_we,  0);
        chk("wr_c2_madr", bus.mem_adr, 32'h100);
        tick();
        chk("wr_c3_rvalid1", bus.r1_rvalid, 1);
        chk("wr_c3_rvalid0", bus.r0_rvalid, 0);
        chk("wr_c3_rdata1",  bus.r1_rdata,  0);
        bus.r1_req = 1'b0; bus.r1_we = 1'b0;
        tick();
        chk("wr_c4_busy", bus.busy, 0);

        // r0 drops req and moves adr after the accepting edge
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_adr = 32'h40;
        bus.mem_rd = 32'hCAFE_0001;
        tick();
        bus.r0_req = 1'b0; bus.r0_adr = 32'h80;
        #1;
        chk("drop_c1_madr", bus.mem_adr, 32'h40);
        tick();
        chk("drop_c2_madr", bus.mem_adr, 32'h40);
        tick();
        chk("drop_c3_rvalid", bus.r0_rvalid, 1);
        chk("drop_c3_rdata",  bus.r0_rdata,  32'hCAFE_0001);
        tick();
        chk("drop_c4_busy", bus.busy, 0);

        // Reset in the second ACCESS cycle of a write aborts it
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_adr = 32'h300; bus.r0_wdata = 32'h1111_2222;
        tick();
        chk("abort_c1_mwe", bus.mem_we, 1);
        bus.r0_req = 1'b0; bus.r0_we = 1'b0;
        tick();
        chk("abort_c2_busy", bus.busy, 1);
        chk("abort_c2_mwe",  bus.mem_we, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", bus.busy,    0);
        chk("abort_gnt0", bus.r0_gnt,  0);
        chk("abort_mwe",  bus.mem_we,  0);
        chk("abort_madr", bus.mem_adr, 0);
        chk("abort_rdata0", bus.r0_rdata, 0);
        seen = 0;
        repeat (2) begin
            tick();
            seen += int'(bus.r0_rvalid) + int'(bus.r1_rvalid);
        end
        reset = 1'b1;
        repeat (3) begin
            tick();
            seen += int'(bus.r0_rvalid) + int'(bus.r1_rvalid) + int'(bus.busy);
        end
        chk("abort_no_rvalid", seen, 0);

        // Continuous contention for four transactions
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_adr = 32'h40;
        bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_adr = 32'h200;
        bus.mem_rd = 32'h0000_0AAA;
        ngr  = 0;
        both = 0;
        pb   = bus.busy;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            tick();
            if (bus.r0_gnt && bus.r1_gnt) both++;
            if (bus.busy && !pb) begin
                gwin[ngr] = bus.r1_gnt;
                gcyc[ngr] = c;
                chk("cont_madr", bus.mem_adr, bus.r1_gnt ? 32'h200 : 32'h40);
                ngr++;
            end
            pb = bus.busy;
        end
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
        chk("cont_count", ngr, 4);
        chk("cont_both_gnt", both, 0);
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_win = (i % 2) == 1;
`else
            exp_win = 1'b0;
`endif
            chk($sformatf("cont_win%0d", i), {31'd0, gwin[i]}, {31'd0, exp_win});
        end
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("cont_space%0d", i), gcyc[i] - gcyc[i-1], 4);
        end
        for (int c = 0; c < 10 && bus.busy; c++) tick();
        chk("cont_drain", bus.busy, 0);

        // WAIT_CYCLES=1 instance: one-cycle ACCESS
        bus2.r0_req = 1'b1; bus2.r0_adr = 32'h44; bus2.mem_rd = 32'h0BAD_F00D;
        tick();
        chk("w1_rd_gnt",    bus2.r0_gnt,    1);
        chk("w1_rd_madr",   bus2.mem_adr,   32'h44);
        chk("w1_rd_rvalid", bus2.r0_rvalid, 0);
        bus2.r0_req = 1'b0;
        tick();
        chk("w1_rd_rvalid2", bus2.r0_rvalid, 1);
        chk("w1_rd_rdata",   bus2.r0_rdata,  32'h0BAD_F00D);
        tick();
        chk("w1_rd_idle",    bus2.busy,      0);
        chk("w1_rd_rvalid3", bus2.r0_rvalid, 0);
        bus2.r1_req = 1'b1; bus2.r1_we = 1'b1; bus2.r1_adr = 32'h48; bus2.r1_wdata = 32'h77;
        tick();
        chk("w1_wr_mwe", bus2.mem_we, 1);
        chk("w1_wr_mwd", bus2.mem_wd, 32'h77);
        bus2.r1_req = 1'b0;
        tick();
        chk("w1_wr_mwe2",   bus2.mem_we,    0);
        chk("w1_wr_rvalid", bus2.r1_rvalid, 1);
        chk("w1_wr_rdata",  bus2.r1_rdata,  0);
        tick();
        chk("w1_wr_idle", bus2.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
